// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed 3-cycle sequencer sharing one single-port data memory
// between the pipeline MEM stage (port 0) and a loader/debug master (port 1).
//
// Handshake: a requester holds pN_req high with stable fields until pN_ack pulses
// for one cycle, and drops or replaces the request in the cycle after the ack.
// pN_err and pN_data_o are valid with the ack. pN_data_o then holds until that
// port's next ack.
//
// dbg_state encoding: 0 = IDLE, 1 = ACCESS, 2 = COMPLETE.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_dmem,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_data_w,
  input  logic              p1_req,
  input  logic              p1_dmem,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_data_w,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_dmem,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_data_w,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic              rd_q, rd_d;
  logic              rerr_q, rerr_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              mem_dmem_q, mem_dmem_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_w_q, mem_data_w_d;

  logic              el0, el1, sel;
  logic              sel_dmem, sel_err;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    // A port whose ack is showing this cycle is finishing, not asking again.
    el0      = p0_req & ~ack_q[0];
    el1      = p1_req & ~ack_q[1];
    sel      = (el0 & el1) ? ptr_q : el1;
    sel_dmem = sel ? p1_dmem   : p0_dmem;
    sel_addr = sel ? p1_addr   : p0_addr;
    sel_data = sel ? p1_data_w : p0_data_w;
    sel_err  = (sel_addr >> ADDR_W) != 32'd0;

    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    rd_d         = rd_q;
    rerr_d       = rerr_q;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    data0_d      = data0_q;
    data1_d      = data1_q;
    mem_dmem_d   = 1'b1;
    mem_addr_d   = mem_addr_q;
    mem_data_w_d = mem_data_w_q;

    case (state_q)
      ST_IDLE: begin
        if (el0 | el1) begin
          state_d      = ST_ACCESS;
          gnt_d        = sel;
          ptr_d        = ~sel;
          rd_d         = sel_dmem & ~sel_err;
          rerr_d       = sel_err;
          // An out-of-range access is turned into a harmless read of word 0.
          mem_dmem_d   = sel_dmem | sel_err;
          mem_addr_d   = sel_err ? 32'd0 : sel_addr;
          mem_data_w_d = sel_data;
        end
      end
      ST_ACCESS: begin
        state_d = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        state_d      = ST_IDLE;
        ack_d[gnt_q] = 1'b1;
        err_d[gnt_q] = rerr_q;
        if (rerr_q || rd_q) begin
          if (gnt_q) data1_d = rerr_q ? '0 : mem_data_i;
          else       data0_d = rerr_q ? '0 : mem_data_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      rd_q         <= 1'b0;
      rerr_q       <= 1'b0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      data0_q      <= '0;
      data1_q      <= '0;
      mem_dmem_q   <= 1'b1;
      mem_addr_q   <= 32'd0;
      mem_data_w_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      rd_q         <= rd_d;
      rerr_q       <= rerr_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      mem_dmem_q   <= mem_dmem_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_w_q <= mem_data_w_d;
    end
  end

  assign p0_ack     = ack_q[0];
  assign p1_ack     = ack_q[1];
  assign p0_err     = err_q[0];
  assign p1_err     = err_q[1];
  assign p0_data_o  = data0_q;
  assign p1_data_o  = data1_q;
  assign mem_dmem   = mem_dmem_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_w = mem_data_w_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule
